rr_arb_mux: RTL and testbench

//   Registered N:1 arbitrating multiplexer with valid/ready handshake on every

---
 rtl/rr_arb_mux.sv | 106 ++++++++++
 tb/tb_rr_arb_mux.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arb_mux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : rr_arb_mux                                                        |
// | Brief  : Registered N:1 arbitrating mux, round-robin or fixed priority,    |
// |          valid/ready on every port with a single-entry output register.    |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module rr_arb_mux #(
  parameter int Inputs     = 4,
  parameter int Width      = 8,
  parameter int RoundRobin = 1,
  localparam int IdxW      = (Inputs > 1) ? $clog2(Inputs) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [Inputs-1:0] in_valid,
  output logic [Inputs-1:0] in_ready,
  input  logic [Width-1:0]  in_data [Inputs],
  output logic              out_valid,
  input  logic              out_ready,
  output logic [Width-1:0]  out_data,
  output logic [IdxW-1:0]   out_sel
);

  logic            free;
  logic            any_valid;
  logic            xfer;
  logic [IdxW-1:0] winner;
  logic [IdxW-1:0] ptr;

  assign free      = !out_valid || out_ready;
  assign any_valid = |in_valid;
  // No grants while reset is held, so in_ready stays low with the outputs.
  assign xfer      = free && any_valid && rst_n;

  generate
    if (Inputs == 1) begin : g_single
      assign winner   = '0;
      assign ptr      = '0;
      assign in_ready = xfer;
    end else begin : g_multi
      logic [IdxW:0] cand;
      logic          found;

      // Scan ptr, ptr+1, ... wrapping; the first requester wins.
      always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int k = 0; k < Inputs; k++) begin
          cand = {1'b0, ptr} + (IdxW+1)'(k);
          if (cand >= (IdxW+1)'(Inputs)) begin
            cand = cand - (IdxW+1)'(Inputs);
          end
          if (!found && in_valid[cand[IdxW-1:0]]) begin
            winner = cand[IdxW-1:0];
            found  = 1'b1;
          end
        end
      end

      always_comb begin
        in_ready = '0;
        if (xfer) begin
          in_ready[winner] = 1'b1;
        end
      end

      if (RoundRobin != 0) begin : g_rr
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            ptr <= '0;
          end else if (xfer) begin
            ptr <= (winner == IdxW'(Inputs - 1)) ? '0 : winner + 1'b1;
          end
        end
      end else begin : g_fixed
        assign ptr = '0;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data[winner];
      out_sel   <= winner;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifndef SYNTHESIS
  a_ready_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(in_ready));

  a_stall_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_sel)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_rr_arb_mux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_rr_arb_mux                                                     |
// | Brief  : Scoreboard bench for rr_arb_mux, round-robin and fixed priority.  |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_rr_arb_mux;

  localparam int N = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] in_valid;
  logic [W-1:0] in_data [N];
  logic         out_ready;

  logic [N-1:0] rr_in_ready, fp_in_ready;
  logic         rr_out_valid, fp_out_valid;
  logic [W-1:0] rr_out_data, fp_out_data;
  logic [1:0]   rr_out_sel, fp_out_sel;

  always #5 clk = ~clk;

  rr_arb_mux #(.Inputs(N), .Width(W), .RoundRobin(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rr_in_ready),
    .in_data(in_data), .out_valid(rr_out_valid), .out_ready(out_ready),
    .out_data(rr_out_data), .out_sel(rr_out_sel)
  );

  rr_arb_mux #(.Inputs(N), .Width(W), .RoundRobin(0)) dut_fp (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(fp_in_ready),
    .in_data(in_data), .out_valid(fp_out_valid), .out_ready(out_ready),
    .out_data(fp_out_data), .out_sel(fp_out_sel)
  );

  bit           rr_mode;
  logic [N-1:0] in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   out_sel;

  always_comb begin
    if (rr_mode) begin
      in_ready  = rr_in_ready;
      out_valid = rr_out_valid;
      out_data  = rr_out_data;
      out_sel   = rr_out_sel;
    end else begin
      in_ready  = fp_in_ready;
      out_valid = fp_out_valid;
      out_data  = fp_out_data;
      out_sel   = fp_out_sel;
    end
  end

  int           n_checks = 0;
  int           n_pass   = 0;
  int           m_ptr;
  logic [9:0]   exp_q[$];
  logic [N-1:0] granted;
  int           wait_cnt [N];
  bit           fair_on;
  logic [5:0]   seq [N];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Called one time unit after the active edge with this cycle's inputs set.
  task automatic step();
    int     win;
    bit     found;
    bit     exp_free;
    logic [N-1:0] exp_ready;
    #1;
    found = 1'b0;
    win   = 0;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (!found && in_valid[c]) begin
        win   = c;
        found = 1'b1;
      end
    end
    exp_free  = (exp_q.size() == 0) || out_ready;
    exp_ready = (found && exp_free) ? (N'(1) << win) : '0;
    check("in_ready", in_ready, exp_ready);
    granted = in_ready & in_valid;
    for (int i = 0; i < N; i++) begin
      if (granted[i]) begin
        if (fair_on) check("fairness", wait_cnt[i] <= N - 1, 1);
        wait_cnt[i] = 0;
      end else if (in_valid[i]) begin
        if (granted != '0) wait_cnt[i]++;
      end else begin
        wait_cnt[i] = 0;
      end
    end
    if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
    if (found && exp_free) begin
      exp_q.push_back({2'(win), in_data[win]});
      if (rr_mode) m_ptr = (win == N - 1) ? 0 : win + 1;
    end
    @(posedge clk);
    #1;
    check("out_valid", out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      check("out_sel", out_sel, exp_q[0][9:8]);
      check("out_data", out_data, exp_q[0][7:0]);
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = N'($urandom);
    out_ready = 1'($urandom);
    for (int i = 0; i < N; i++) in_data[i] = W'($urandom);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_sel", out_sel, 0);
    check("rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = '0;
    exp_q.delete();
    m_ptr = 0;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
  endtask

  initial begin
    rr_mode   = 1'b1;
    fair_on   = 1'b0;
    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) in_data[i] = '0;
    @(posedge clk);
    #1;

    // 1: reset values, then reset asserted while a beat is held
    do_reset();
    in_valid   = 4'b0001;
    in_data[0] = 8'h3C;
    out_ready  = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    do_reset();

    // 2: rotating priority with all channels requesting
    for (int i = 0; i < N; i++) in_data[i] = 8'hA0 + 8'(i);
    in_valid  = 4'hF;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      check("rr_seq_sel", out_sel, k % N);
      check("rr_seq_data", out_data, 8'hA0 + (k % N));
    end

    // 3: backpressure holds the beat, release reloads without a bubble
    in_data[0] = 8'h55;
    step();
    check("bp_first", out_data, 8'h55);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check("bp_hold", out_data, 8'h55);
      check("bp_no_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    step();
    check("bp_next", out_data, 8'hA1);

    // 4: sparse requests, pointer now at 2
    in_valid = 4'b1010;
    step();
    check("sparse_first", out_sel, 3);
    step();
    check("sparse_second", out_sel, 1);
    in_valid = '0;
    step();
    step();

    // 5: fixed priority
    rr_mode = 1'b0;
    do_reset();
    for (int i = 0; i < N; i++) in_data[i] = 8'hC0 + 8'(i);
    in_valid  = 4'b0101;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("fp_ch0", out_sel, 0);
    end
    in_valid = 4'b0100;
    step();
    check("fp_ch2", out_sel, 2);
    in_valid = '0;
    step();

    // 6: random traffic with per-channel sequence-tagged payloads
    rr_mode = 1'b1;
    do_reset();
    fair_on = 1'b1;
    for (int i = 0; i < N; i++) begin
      seq[i]      = '0;
      in_data[i]  = {2'(i), seq[i]};
      in_valid[i] = 1'($urandom);
    end
    for (int n = 0; n < 600; n++) begin
      out_ready = ($urandom_range(0, 9) < 7);
      step();
      for (int i = 0; i < N; i++) begin
        if (granted[i]) begin
          seq[i]     = seq[i] + 6'd1;
          in_data[i] = {2'(i), seq[i]};
        end
        if (granted[i] || !in_valid[i]) in_valid[i] = ($urandom_range(0, 2) != 0);
      end
    end
    in_valid  = '0;
    out_ready = 1'b1;
    step();
    step();
    check("drained", out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
